// File: rtl/omsp_hmac_byte_if_pkg.sv
// Shared types and constants for the HMAC byte adapter: state encoding and the
// byte order used both when absorbing and when squeezing 16-bit words.
package omsp_hmac_byte_if_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  // Big-endian: the first byte on the wire is word[15:8].
  localparam int unsigned FIRST_LSB  = 8;
  localparam int unsigned SECOND_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS_HI = 3'd1,
    ST_ABS_LO = 3'd2,
    ST_FINAL  = 3'd3,
    ST_SQ_HI  = 3'd4,
    ST_SQ_LO  = 3'd5
  } state_t;

  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w, input logic first);
    return first ? w[FIRST_LSB +: BYTE_W] : w[SECOND_LSB +: BYTE_W];
  endfunction

endpackage

// File: rtl/omsp_hmac_byte_if_if.sv
// Byte-wide link between the adapter (master) and the sponge hash core (slave).
interface omsp_hmac_byte_if_if;
  import omsp_hmac_byte_if_pkg::*;

  logic              core_clear;
  logic              core_in_valid;
  logic [BYTE_W-1:0] core_in_byte;
  logic              core_in_ready;
  logic              core_final;
  logic              core_final_ack;
  logic              core_out_ready;
  logic              core_out_valid;
  logic [BYTE_W-1:0] core_out_byte;

  modport master (
    output core_clear, core_in_valid, core_in_byte, core_final, core_out_ready,
    input  core_in_ready, core_final_ack, core_out_valid, core_out_byte
  );

  modport slave (
    input  core_clear, core_in_valid, core_in_byte, core_final, core_out_ready,
    output core_in_ready, core_final_ack, core_out_valid, core_out_byte
  );
endinterface

// File: rtl/omsp_hmac_byte_if_sq.sv
// Squeeze deserialiser: assembles two core bytes into the digest word and counts
// squeezed words, saturating at OUT_WORDS.
module omsp_hmac_byte_if_sq
  import omsp_hmac_byte_if_pkg::*;
#(
  parameter int unsigned OUT_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              cap_hi,
  input  logic              cap_lo,
  input  logic              ovf,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] hash_out,
  output logic              full_c
);

  localparam int unsigned CNT_W = $clog2(OUT_WORDS + 1);

  logic [CNT_W-1:0] count;

  assign full_c = (count == CNT_W'(OUT_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hash_out <= '0;
      count    <= '0;
    end else if (clr) begin
      hash_out <= '0;
      count    <= '0;
    end else begin
      if (ovf) hash_out <= '0;
      if (cap_hi) hash_out[FIRST_LSB +: BYTE_W] <= byte_in;
      if (cap_lo) begin
        hash_out[SECOND_LSB +: BYTE_W] <= byte_in;
        if (!full_c) count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/omsp_hmac_byte_if.sv
// Adapter between the HMAC sequencing FSM and the byte-wide sponge core:
// serialises absorbed words, runs one finalisation, deserialises digest words.
module omsp_hmac_byte_if
  import omsp_hmac_byte_if_pkg::*;
#(
  parameter int unsigned OUT_WORDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hmac_reset,
  input  logic              start_continue,
  input  logic              data_available,
  input  logic              data_is_long,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic [WORD_W-1:0] hash_out,
  output logic              protocol_err,
  omsp_hmac_byte_if_if.master core
);

  state_t            state, state_nx;
  logic              start_q, start_edge;
  logic              finalised;
  logic [WORD_W-1:0] word_q;
  logic              load_word, set_fin, set_perr, ovf, cap_hi, cap_lo;
  logic              sq_full_c;

  // Upstream samples busy in the very cycle start first rises.
  assign start_edge = start_continue & ~start_q & ~hmac_reset;
  assign busy       = (state != ST_IDLE) | start_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
    end else if (hmac_reset) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start_continue;
    end
  end

  always_comb begin
    state_nx  = state;
    load_word = 1'b0;
    set_fin   = 1'b0;
    set_perr  = 1'b0;
    ovf       = 1'b0;
    cap_hi    = 1'b0;
    cap_lo    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          load_word = 1'b1;
          if (data_available) begin
            if (finalised)         set_perr = 1'b1;
            else if (data_is_long) state_nx = ST_ABS_HI;
            else                   state_nx = ST_ABS_LO;
          end else if (!finalised) begin
            state_nx = ST_FINAL;
          end else if (sq_full_c) begin
            ovf      = 1'b1;
            set_perr = 1'b1;
          end else begin
            state_nx = ST_SQ_HI;
          end
        end
      end
      ST_ABS_HI: if (core.core_in_ready) state_nx = ST_ABS_LO;
      ST_ABS_LO: if (core.core_in_ready) state_nx = ST_IDLE;
      ST_FINAL: begin
        if (core.core_final_ack) begin
          set_fin  = 1'b1;
          state_nx = ST_SQ_HI;
        end
      end
      ST_SQ_HI: begin
        if (core.core_out_valid) begin
          cap_hi   = 1'b1;
          state_nx = ST_SQ_LO;
        end
      end
      ST_SQ_LO: begin
        if (core.core_out_valid) begin
          cap_lo   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q       <= '0;
      finalised    <= 1'b0;
      protocol_err <= 1'b0;
    end else if (hmac_reset) begin
      word_q       <= '0;
      finalised    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (load_word) word_q       <= data_in;
      if (set_fin)   finalised    <= 1'b1;
      if (set_perr)  protocol_err <= 1'b1;
    end
  end

  omsp_hmac_byte_if_sq #(.OUT_WORDS(OUT_WORDS)) u_sq (
    .clk      (clk),
    .reset    (reset),
    .clr      (hmac_reset),
    .cap_hi   (cap_hi),
    .cap_lo   (cap_lo),
    .ovf      (ovf),
    .byte_in  (core.core_out_byte),
    .hash_out (hash_out),
    .full_c   (sq_full_c)
  );

  // Core strobes decode directly from the state register.
  assign core.core_clear     = hmac_reset | reset;
  assign core.core_in_valid  = (state == ST_ABS_HI) | (state == ST_ABS_LO);
  assign core.core_in_byte   = core.core_in_valid ? word_byte(word_q, state == ST_ABS_HI) : '0;
  assign core.core_final     = (state == ST_FINAL);
  assign core.core_out_ready = (state == ST_SQ_HI) | (state == ST_SQ_LO);

endmodule

// File: tb/tb_omsp_hmac_byte_if.sv
// Bench for omsp_hmac_byte_if: directed test-plan steps plus randomised
// absorb/squeeze traffic against a word-level reference model.
module tb_omsp_hmac_byte_if;
  localparam int unsigned OUT_WORDS = 8;

  logic        clk = 1'b0;
  logic        reset, hmac_reset, start_continue, data_available, data_is_long;
  logic [15:0] data_in;
  logic        busy, protocol_err;
  logic [15:0] hash_out;

  omsp_hmac_byte_if_if bus ();

  omsp_hmac_byte_if #(.OUT_WORDS(OUT_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .hmac_reset     (hmac_reset),
    .start_continue (start_continue),
    .data_available (data_available),
    .data_is_long   (data_is_long),
    .data_in        (data_in),
    .busy           (busy),
    .hash_out       (hash_out),
    .protocol_err   (protocol_err),
    .core           (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Core-side model state
  logic       rdy_r = 1'b1, ack_r = 1'b0, oval_r = 1'b0;
  logic [7:0] obyte_r = 8'h00;
  assign bus.core_in_ready  = rdy_r;
  assign bus.core_final_ack = ack_r;
  assign bus.core_out_valid = oval_r;
  assign bus.core_out_byte  = obyte_r;

  int         in_mode = 0, in_vcnt = 0, sq_mode = 0;
  int         fin_delay = 1, fin_cnt = 0, fin_cycles = 0, fin_events = 0;
  int         act_in = 0, act_out = 0, stab_err = 0, src_idx = 0;
  logic [7:0] got_q[$];
  logic [7:0] src[64];

  // Reference model
  logic [15:0] m_hash = 16'h0;
  bit          m_perr = 0, m_fin = 0;
  int          m_cnt = 0, m_k = 0, m_fin_events = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sponge core responder: all decisions at the falling edge, for the next rising edge.
  initial begin : core_model
    logic       prev_hold = 1'b0, out_x = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    forever begin
      @(negedge clk);
      case (in_mode)
        0:       rdy_r = 1'b1;
        1:       rdy_r = 1'($urandom_range(0, 1));
        default: rdy_r = !(in_vcnt >= 1 && in_vcnt <= 4);
      endcase
      if (bus.core_in_valid) begin
        if (prev_hold && bus.core_in_byte !== prev_byte) stab_err++;
        in_vcnt++;
        act_in++;
        if (rdy_r) got_q.push_back(bus.core_in_byte);
      end else if (prev_hold) begin
        stab_err++;
      end
      prev_hold = bus.core_in_valid && !rdy_r;
      prev_byte = bus.core_in_byte;

      if (bus.core_final) begin
        fin_cnt++;
        if (fin_cnt >= fin_delay && !ack_r) begin
          ack_r = 1'b1;
          fin_cycles = fin_cnt;
          fin_events++;
        end
      end else begin
        fin_cnt = 0;
        ack_r   = 1'b0;
      end

      if (out_x) begin
        src_idx++;
        oval_r = 1'b0;
      end
      if (bus.core_out_ready && !oval_r &&
          (sq_mode == 0 || (sq_mode == 1 && $urandom_range(0, 2) == 0))) begin
        oval_r  = 1'b1;
        obyte_r = src[src_idx % 64];
      end
      if (bus.core_out_ready) act_out++;
      out_x = oval_r && bus.core_out_ready;
    end
  end

  task automatic model_op(input bit avail, input bit lng, input logic [15:0] d);
    if (avail) begin
      if (m_fin) m_perr = 1;
      else begin
        if (lng) exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
      end
    end else if (m_cnt == OUT_WORDS) begin
      m_hash = 16'h0;
      m_perr = 1;
    end else begin
      if (!m_fin) m_fin_events++;
      m_fin  = 1;
      m_hash = {src[m_k % 64], src[(m_k + 1) % 64]};
      m_k   += 2;
      m_cnt++;
    end
  endtask

  // One upstream operation; start_continue is held for a random 1..3 cycles.
  task automatic run_op(input bit avail, input bit lng, input logic [15:0] d,
                        output int bcyc, output int d_in, output int d_out);
    int hold, a0, o0, bad;
    hold = $urandom_range(1, 3);
    a0 = act_in; o0 = act_out;
    model_op(avail, lng, d);
    start_continue = 1'b1; data_available = avail; data_is_long = lng; data_in = d;
    #1 chk("busy_on_edge", 32'(busy), 32'd1);
    bcyc = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i + 1 >= hold) start_continue = 1'b0;
      data_in = 16'($urandom);
      #1;
      if (!busy) break;
      bcyc++;
    end
    chk("op_complete", 32'(busy), 32'd0);
    start_continue = 1'b0;
    @(negedge clk);
    chk("op_busy_idle", 32'(busy), 32'd0);
    d_in = act_in - a0; d_out = act_out - o0;
    chk("hash_out", 32'(hash_out), 32'(m_hash));
    chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    chk("absorbed_count", 32'(got_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    chk("absorbed_bytes", 32'(bad), 32'd0);
    chk("final_events", 32'(fin_events), 32'(m_fin_events));
  endtask

  initial begin : stim
    int bc, di, dout;
    for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
    src[0] = 8'h12; src[1] = 8'h34;
    reset = 1'b1; hmac_reset = 1'b0; start_continue = 1'b0;
    data_available = 1'b0; data_is_long = 1'b0; data_in = 16'h0;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hash", 32'(hash_out), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    chk("rst_core_clear", 32'(bus.core_clear), 32'd1);
    chk("rst_in_valid", 32'(bus.core_in_valid), 32'd0);
    chk("rst_final", 32'(bus.core_final), 32'd0);
    chk("rst_out_ready", 32'(bus.core_out_ready), 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("core_clear_released", 32'(bus.core_clear), 32'd0);

    // Start edges are ignored while hmac_reset is high
    @(negedge clk); hmac_reset = 1'b1; start_continue = 1'b1; data_available = 1'b1;
    #1 chk("hreset_core_clear", 32'(bus.core_clear), 32'd1);
    chk("hreset_edge_ignored", 32'(busy), 32'd0);
    @(negedge clk); #1 chk("hreset_no_op", 32'(bus.core_in_valid), 32'd0);
    start_continue = 1'b0; hmac_reset = 1'b0;
    @(negedge clk);

    // Long absorb, zero-wait core
    in_mode = 0;
    run_op(1, 1, 16'hA55A, bc, di, dout);
    chk("long_busy_cycles", 32'(bc), 32'd3);
    chk("long_byte_hi", 32'(got_q[got_q.size()-2]), 32'hA5);
    chk("long_byte_lo", 32'(got_q[got_q.size()-1]), 32'h5A);

    // Short absorb (padding byte)
    run_op(1, 0, 16'h0001, bc, di, dout);
    chk("short_busy_cycles", 32'(bc), 32'd2);
    chk("short_byte", 32'(got_q[got_q.size()-1]), 32'h01);
    chk("short_one_valid", 32'(di), 32'd1);

    // Random absorbs under random backpressure
    in_mode = 1;
    for (int n = 0; n < 12; n++) run_op(1, 1'($urandom_range(0, 1)), 16'($urandom), bc, di, dout);

    // Backpressure: ready low for 4 cycles while the low byte is offered
    in_mode = 2; in_vcnt = 0;
    run_op(1, 1, 16'hC33C, bc, di, dout);
    chk("bp_busy_cycles", 32'(bc), 32'd7);
    chk("bp_valid_cycles", 32'(di), 32'd6);
    chk("bp_stable", 32'(stab_err), 32'd0);
    in_mode = 0;

    // Finalise (ack after 5 cycles) and first squeeze
    fin_delay = 5; sq_mode = 0;
    run_op(0, 0, 16'h0, bc, di, dout);
    chk("fin_cycles", 32'(fin_cycles), 32'd5);
    chk("first_digest", 32'(hash_out), 32'h1234);
    chk("word_count_1", 32'(dut.u_sq.count), 32'd1);
    chk("fin_busy_cycles", 32'(bc), 32'd8);

    // Remaining squeezes with random core stalls
    sq_mode = 1;
    for (int n = 1; n < OUT_WORDS; n++) run_op(0, 0, 16'($urandom), bc, di, dout);
    chk("word_count_full", 32'(dut.u_sq.count), 32'(OUT_WORDS));
    chk("perr_before_ovf", 32'(protocol_err), 32'd0);

    // Overflow squeeze
    run_op(0, 0, 16'h0, bc, di, dout);
    chk("ovf_hash_zero", 32'(hash_out), 32'd0);
    chk("ovf_perr", 32'(protocol_err), 32'd1);
    chk("ovf_no_out_ready", 32'(dout), 32'd0);
    chk("ovf_busy_cycles", 32'(bc), 32'd1);
    chk("word_count_sat", 32'(dut.u_sq.count), 32'(OUT_WORDS));

    // Clear, then finalise again and try an illegal absorb
    @(negedge clk); hmac_reset = 1'b1;
    @(negedge clk); hmac_reset = 1'b0;
    m_hash = 16'h0; m_perr = 0; m_fin = 0; m_cnt = 0;
    #1 chk("clr_perr", 32'(protocol_err), 32'd0);
    chk("clr_count", 32'(dut.u_sq.count), 32'd0);
    @(negedge clk);
    fin_delay = $urandom_range(1, 4);
    run_op(0, 0, 16'h0, bc, di, dout);
    run_op(1, 1, 16'hBEEF, bc, di, dout);
    chk("illegal_abs_no_valid", 32'(di), 32'd0);
    chk("illegal_abs_perr", 32'(protocol_err), 32'd1);

    // hmac_reset while parked in SQ_HI
    sq_mode = 2;
    start_continue = 1'b1; data_available = 1'b0;
    for (int i = 0; i < 20 && !bus.core_out_ready; i++) @(negedge clk);
    chk("reached_sq_hi", 32'(bus.core_out_ready), 32'd1);
    start_continue = 1'b0; hmac_reset = 1'b1;
    @(negedge clk); #1;
    chk("abort_out_ready", 32'(bus.core_out_ready), 32'd0);
    chk("abort_core_clear", 32'(bus.core_clear), 32'd1);
    chk("abort_hash_zero", 32'(hash_out), 32'd0);
    chk("abort_perr_zero", 32'(protocol_err), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    hmac_reset = 1'b0;
    m_hash = 16'h0; m_perr = 0; m_fin = 0; m_cnt = 0;
    @(negedge clk);

    // Absorb is legal again after the clear
    in_mode = 1; sq_mode = 0;
    run_op(1, 1, 16'($urandom), bc, di, dout);
    chk("stable_overall", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
